// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the enabled register.
// Parity support is compiled in with DFF_PARITY_EN.
package dff_pkg;

  localparam int DFF_WIDTH_DEFAULT = 1;
  localparam int DFF_RESET_VAL_DEFAULT = 0;

  // Zero extension to 64 bits leaves the XOR unchanged.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dff_parity_gen.sv
// XOR reduction of a WIDTH-bit bus.
// Instantiated by dff_enable only when DFF_PARITY_EN is defined.
module dff_parity_gen #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d,
  output logic             p
);

  assign p = ^d;

endmodule

// File: rtl/dff_enable.sv
// Clock-enabled register with synchronous active-low reset.
// Defining DFF_PARITY_EN adds a stored parity bit and io_PERR.
module dff_enable
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL =
    WIDTH'(DFF_RESET_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_D,
  input  logic             io_EN,
  output logic [WIDTH-1:0] io_Q
`ifdef DFF_PARITY_EN
  ,
  output logic             io_PERR
`endif
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_Q <= RESET_VAL;
    end else if (io_EN) begin
      io_Q <= io_D;
    end
  end

`ifdef DFF_PARITY_EN
  localparam logic RESET_PAR = parity(64'(RESET_VAL));

  logic d_par;
  logic q_par;
  logic par_q;

  dff_parity_gen #(.WIDTH(WIDTH)) u_d_par (
    .d (io_D),
    .p (d_par)
  );

  dff_parity_gen #(.WIDTH(WIDTH)) u_q_par (
    .d (io_Q),
    .p (q_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= RESET_PAR;
    end else if (io_EN) begin
      par_q <= d_par;
    end
  end

  assign io_PERR = q_par != par_q;
`endif

endmodule

// File: tb/tb_dff_enable.sv
// Self-checking bench for dff_enable: 1-bit and 8-bit instances.
// Directed steps followed by randomized steps against a rule model.
module tb_dff_enable;

  localparam logic [7:0] RV8 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;
`ifdef DFF_PARITY_EN
  logic       perr1;
  logic       perr8;
`endif

  logic       m1;
  logic [7:0] m8;
  int         checks = 0;
  int         errors = 0;

  always #120 clk = ~clk;

  dff_enable u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_D  (d1),
    .io_EN (en),
    .io_Q  (q1)
`ifdef DFF_PARITY_EN
    ,
    .io_PERR (perr1)
`endif
  );

  dff_enable #(.WIDTH(8), .RESET_VAL(RV8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_D  (d8),
    .io_EN (en),
    .io_Q  (q8)
`ifdef DFF_PARITY_EN
    ,
    .io_PERR (perr8)
`endif
  );

  task automatic check(input string tag);
    checks++;
    assert (q1 === m1) else begin
      errors++;
      $error("FAIL %s q1 got %b exp %b", tag, q1, m1);
    end
    checks++;
    assert (q8 === m8) else begin
      errors++;
      $error("FAIL %s q8 got %h exp %h", tag, q8, m8);
    end
  endtask

  // Apply the register rules to whatever is on the inputs at the edge.
  task automatic edge_check(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m1 = 1'b0;
      m8 = RV8;
    end else if (en) begin
      m1 = d1;
      m8 = d8;
    end
    #1;
    check(tag);
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic a, input logic [7:0] b,
                       input string tag);
    @(negedge clk);
    rst_n = r;
    en    = e;
    d1    = a;
    d8    = b;
    edge_check(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;
    m1    = 1'bx;
    m8    = 'x;

    drive(1'b0, 1'b1, 1'b1, 8'hFF, "reset_beats_en");
    drive(1'b1, 1'b1, 1'b1, 8'h11, "capture_1");
    drive(1'b1, 1'b1, 1'b0, 8'h22, "capture_0");
    drive(1'b1, 1'b1, 1'b1, 8'hC3, "capture_1b");
    drive(1'b1, 1'b0, 1'b0, 8'h00, "hold_a");
    drive(1'b1, 1'b0, 1'b1, 8'hFF, "hold_b");
    drive(1'b1, 1'b0, 1'b0, 8'h0F, "hold_c");

    // Inputs move between edges; output must not follow.
    #30;
    en = 1'b1;
    d1 = ~m1;
    d8 = ~m8;
    #30;
    check("mid_cycle_no_change");
    d8 = 8'h96;
    #20;
    check("mid_cycle_no_change2");
    edge_check("timing_edge");

    // Mid-cycle reset waits for the next edge.
    drive(1'b1, 1'b1, 1'b1, 8'hE7, "pre_reset");
    #40;
    rst_n = 1'b0;
    #20;
    check("reset_mid_cycle");
    edge_check("reset_at_edge");
    drive(1'b1, 1'b1, 1'b1, 8'h81, "reset_release");

`ifdef DFF_PARITY_EN
    drive(1'b1, 1'b1, 1'b1, 8'hA5, "par_cap_a5");
    checks++;
    assert (perr8 === 1'b0) else begin
      errors++;
      $error("FAIL par_a5 perr got %b exp 0", perr8);
    end
    @(negedge clk);
    en = 1'b0;
    force u8.io_Q = 8'hA4;
    #1;
    checks++;
    assert (perr8 === 1'b1) else begin
      errors++;
      $error("FAIL par_force perr got %b exp 1", perr8);
    end
    release u8.io_Q;
    drive(1'b1, 1'b1, 1'b0, 8'h3C, "par_cap_3c");
    checks++;
    assert (perr8 === 1'b0) else begin
      errors++;
      $error("FAIL par_3c perr got %b exp 0", perr8);
    end
`endif

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) != 0),
            1'($urandom),
            1'($urandom),
            8'($urandom),
            "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
